gcd_controller: RTL

//   FSM that sequences the GCD datapath. It accepts an operand pair over a valid/ready handshake,

---
 rtl/gcd_controller_pkg.sv | 25 ++
 rtl/gcd_controller_iter_counter.sv | 36 +++
 rtl/gcd_controller.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/gcd_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gcd_controller_pkg
// Purpose : Shared state encodings, widths and helpers for the GCD controller.
// Revision: 1.0 - initial release
// ============================================================================
package gcd_controller_pkg;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [1:0] {
        GCD_IDLE = 2'd0,
        GCD_CMP  = 2'd1,
        GCD_DONE = 2'd2,
        GCD_ERR  = 2'd3
    } gcd_state_t;

    // The datapath drives exactly one compare flag per cycle.
    function automatic logic flags_onehot(input logic gt, input logic eq, input logic lt);
        return ({gt, eq, lt} == 3'b100) || ({gt, eq, lt} == 3'b010) ||
               ({gt, eq, lt} == 3'b001);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gcd_controller_iter_counter.sv
`default_nettype none
// ============================================================================
// Module  : gcd_controller_iter_counter
// Purpose : Saturating iteration counter used as the GCD watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module gcd_controller_iter_counter #(
    parameter int ITER_W   = 17,
    parameter int MAX_ITER = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_max
);

    localparam logic [ITER_W-1:0] c_max = ITER_W'(MAX_ITER);

    logic [ITER_W-1:0] r_count;

    // Holds at the limit instead of wrapping so the watchdog cannot be missed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_max = (r_count == c_max);

endmodule
`default_nettype wire

// File: rtl/gcd_controller.sv
`default_nettype none
// ============================================================================
// Module  : gcd_controller
// Purpose : Handshaked sequencer for the subtractive GCD datapath with watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module gcd_controller
    import gcd_controller_pkg::*;
#(
    parameter int WIDTH    = GCD_WIDTH,
    parameter int MAX_ITER = 65535,
    parameter int ITER_W   = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             a_gt_b,
    input  logic             a_eq_b,
    input  logic             a_lt_b,
    output logic             a_sel,
    output logic             b_sel,
    output logic             a_ld,
    output logic             b_ld,
    output logic             output_en,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);

    gcd_state_t r_state;
    gcd_state_t w_next_state;
    logic       w_cnt_clr;
    logic       w_cnt_inc;
    logic       w_at_max;
    logic       w_zero_operand;
    logic       w_take_eq;

    assign w_zero_operand = (in1 == '0) || (in2 == '0);
    // A corrupt flag set is resolved as "equal" so the job always terminates.
    assign w_take_eq      = a_eq_b || !flags_onehot(a_gt_b, a_eq_b, a_lt_b);

    gcd_controller_iter_counter #(
        .ITER_W  (ITER_W),
        .MAX_ITER(MAX_ITER)
    ) u_iter_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .o_at_max(w_at_max)
    );

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        a_sel        = 1'b0;
        b_sel        = 1'b0;
        a_ld         = 1'b0;
        b_ld         = 1'b0;
        output_en    = 1'b0;
        busy         = 1'b0;
        out_valid    = 1'b0;
        err          = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;

        case (r_state)
            GCD_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (w_zero_operand) begin
                        w_next_state = GCD_ERR;
                    end else begin
                        a_sel        = 1'b1;
                        b_sel        = 1'b1;
                        a_ld         = 1'b1;
                        b_ld         = 1'b1;
                        w_cnt_clr    = 1'b1;
                        w_next_state = GCD_CMP;
                    end
                end
            end
            GCD_CMP: begin
                busy = 1'b1;
                if (w_take_eq) begin
                    output_en    = 1'b1;
                    w_next_state = GCD_DONE;
                end else if (w_at_max) begin
                    w_next_state = GCD_ERR;
                end else if (a_gt_b) begin
                    a_ld      = 1'b1;
                    w_cnt_inc = 1'b1;
                end else begin
                    b_ld      = 1'b1;
                    w_cnt_inc = 1'b1;
                end
            end
            GCD_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = GCD_IDLE;
                end
            end
            GCD_ERR: begin
                out_valid = 1'b1;
                err       = 1'b1;
                if (out_ready) begin
                    w_next_state = GCD_IDLE;
                end
            end
            default: begin
                w_next_state = GCD_IDLE;
            end
        endcase

        // While reset is held nothing may reach the datapath or the consumer.
        if (!rst) begin
            a_sel        = 1'b0;
            b_sel        = 1'b0;
            a_ld         = 1'b0;
            b_ld         = 1'b0;
            output_en    = 1'b0;
            busy         = 1'b0;
            out_valid    = 1'b0;
            err          = 1'b0;
            w_cnt_clr    = 1'b0;
            w_cnt_inc    = 1'b0;
            w_next_state = GCD_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= GCD_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

endmodule
`default_nettype wire
